// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the RV32I pipeline.
package riscv_pkg;
    localparam int XLEN = 32;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/load_extend.sv
// load_extend: extracts and sign/zero-extends load data from a memory word.
module load_extend
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misalign
);
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic        isHalf, isByte;

    always_comb begin
        loadByte = word[{offset, 3'b000} +: 8];
        loadHalf = word[{offset[1], 4'b0000} +: 16];
        isByte   = (funct3 == F3_LB) || (funct3 == F3_LBU);
        isHalf   = (funct3 == F3_LH) || (funct3 == F3_LHU);
        // Unlisted funct3 encodings fall through to a full-word load.
        data     = (funct3 == F3_LB)  ? {{(XLEN-8){loadByte[7]}}, loadByte} :
                   (funct3 == F3_LBU) ? {{(XLEN-8){1'b0}}, loadByte} :
                   (funct3 == F3_LH)  ? {{(XLEN-16){loadHalf[15]}}, loadHalf} :
                   (funct3 == F3_LHU) ? {{(XLEN-16){1'b0}}, loadHalf} : word;
        misalign = isByte ? 1'b0 : isHalf ? offset[0] : (offset != 2'b00);
    end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, load extraction, result select, write gating
// and retired-instruction counter.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter int RET_CNT_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 StallW,
    input  logic                 FlushW,
    input  logic                 ValidM,
    input  logic                 RegWriteM,
    input  logic [1:0]           ResultSrcM,
    input  logic [2:0]           Funct3M,
    input  logic [4:0]           RdM,
    input  logic [XLEN-1:0]      ALUResultM,
    input  logic [XLEN-1:0]      ReadDataM,
    input  logic [XLEN-1:0]      PCPlus4M,
    output logic                 RegWriteW,
    output logic [4:0]           RdW,
    output logic [XLEN-1:0]      ResultW,
    output logic                 ValidW,
    output logic                 LoadMisalignW,
    output logic [RET_CNT_W-1:0] InstRetW
);
    logic            regWrite;
    logic [1:0]      resultSrc;
    logic [2:0]      funct3;
    logic [XLEN-1:0] aluResult, readData, pcPlus4, loadData;
    logic            misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidW    <= 1'b0;
            regWrite  <= 1'b0;
            resultSrc <= '0;
            funct3    <= '0;
            RdW       <= '0;
            aluResult <= '0;
            readData  <= '0;
            pcPlus4   <= '0;
            InstRetW  <= '0;
        end else begin
            // Retire is judged on the outgoing instruction, so a flush does not cancel it.
            if (ValidW && !StallW)
                InstRetW <= InstRetW + 1'b1;
            if (FlushW) begin
                ValidW    <= 1'b0;
                regWrite  <= 1'b0;
                resultSrc <= '0;
                funct3    <= '0;
                RdW       <= '0;
                aluResult <= '0;
                readData  <= '0;
                pcPlus4   <= '0;
            end else if (!StallW) begin
                ValidW    <= ValidM;
                regWrite  <= RegWriteM;
                resultSrc <= ResultSrcM;
                funct3    <= Funct3M;
                RdW       <= RdM;
                aluResult <= ALUResultM;
                readData  <= ReadDataM;
                pcPlus4   <= PCPlus4M;
            end
        end
    end

    load_extend #(.XLEN(XLEN)) uExtend (
        .word    (readData),
        .offset  (aluResult[1:0]),
        .funct3  (funct3),
        .data    (loadData),
        .misalign(misalign)
    );

    always_comb begin
        ResultW       = (resultSrc == RES_LOAD) ? loadData :
                        (resultSrc == RES_PC4)  ? pcPlus4 : aluResult;
        LoadMisalignW = ValidW && (resultSrc == RES_LOAD) && misalign;
        RegWriteW     = ValidW && regWrite && (RdW != 5'd0) && !LoadMisalignW;
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed self-checking bench for writeback_stage.
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        rst_n, StallW, FlushW, ValidM, RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, ReadDataM, PCPlus4M;
    logic        RegWriteW, ValidW, LoadMisalignW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [63:0] InstRetW;

    int          nChecks = 0, nFail = 0;
    logic        expValid = 1'b0;
    logic [63:0] expRet = '0;

    writeback_stage dut (
        .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .ValidW(ValidW),
        .LoadMisalignW(LoadMisalignW), .InstRetW(InstRetW)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc4);
        ValidM = v; RegWriteM = rw; ResultSrcM = src; Funct3M = f3; RdM = rd;
        ALUResultM = alu; ReadDataM = rdat; PCPlus4M = pc4;
    endtask

    // Expected valid/retire tracking updated alongside every clock edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            expValid = 1'b0; expRet = '0;
        end else begin
            if (expValid && !StallW) expRet = expRet + 1;
            expValid = FlushW ? 1'b0 : StallW ? expValid : ValidM;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; StallW = 1'b0; FlushW = 1'b0;
        drive(1, 1, 2'b00, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h0);
        tick(); tick();
        nChecks++; if ({RegWriteW, RdW, ResultW, ValidW, LoadMisalignW} !== 39'd0) begin nFail++; $display("FAIL reset_outputs: got rw=%b rd=%0d res=%h v=%b mis=%b, want all 0", RegWriteW, RdW, ResultW, ValidW, LoadMisalignW); end
        nChecks++; if (InstRetW !== 64'd0) begin nFail++; $display("FAIL reset_instret: got %0d want 0", InstRetW); end
        rst_n = 1'b1;
        tick();
        nChecks++; if (RegWriteW !== 1'b1 || RdW !== 5'd5) begin nFail++; $display("FAIL first_rw_rd: got rw=%b rd=%0d want rw=1 rd=5", RegWriteW, RdW); end
        nChecks++; if (ResultW !== 32'h1234) begin nFail++; $display("FAIL first_result: got %h want 00001234", ResultW); end
        nChecks++; if (InstRetW !== 64'd0) begin nFail++; $display("FAIL first_instret_pre: got %0d want 0", InstRetW); end
        drive(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        nChecks++; if (InstRetW !== 64'd1) begin nFail++; $display("FAIL first_instret_post: got %0d want 1", InstRetW); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [7] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
        logic [1:0]  off [7] = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
        logic [31:0] exp [7] = '{32'h00000001, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                 32'h000080FF, 32'h80FF7F01, 32'h80FF7F01};
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, 2'b01, f3[i], 5'd7, 32'h1000 + {30'd0, off[i]}, 32'h80FF7F01, 32'h0);
            tick();
            nChecks++; if (ResultW !== exp[i]) begin nFail++; $display("FAIL load_%0d_data: got %h want %h", i, ResultW, exp[i]); end
            nChecks++; if (RegWriteW !== 1'b1 || LoadMisalignW !== 1'b0) begin nFail++; $display("FAIL load_%0d_ctrl: got rw=%b mis=%b want rw=1 mis=0", i, RegWriteW, LoadMisalignW); end
        end
        drive(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        nChecks++; if (InstRetW !== expRet) begin nFail++; $display("FAIL load_instret: got %0d want %0d", InstRetW, expRet); end
    endtask

    task automatic test_misaligned();
        logic [2:0]  f3   [2] = '{3'b010, 3'b001};
        logic [31:0] addr [2] = '{32'h1002, 32'h1001};
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 2'b01, f3[i], 5'd8, addr[i], 32'h80FF7F01, 32'h0);
            tick();
            nChecks++; if (LoadMisalignW !== 1'b1 || RegWriteW !== 1'b0) begin nFail++; $display("FAIL misalign_%0d: got mis=%b rw=%b want mis=1 rw=0", i, LoadMisalignW, RegWriteW); end
        end
        StallW = 1'b1;
        tick();
        nChecks++; if (LoadMisalignW !== 1'b1) begin nFail++; $display("FAIL misalign_stalled: got %b want 1", LoadMisalignW); end
        StallW = 1'b0;
        drive(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        nChecks++; if (InstRetW !== expRet) begin nFail++; $display("FAIL misalign_instret: got %0d want %0d", InstRetW, expRet); end
    endtask

    task automatic test_stall_flush();
        logic [63:0] held;
        drive(1, 1, 2'b00, 3'b000, 5'd9, 32'hAAAA, 32'h0, 32'h0);
        tick();
        held = InstRetW;
        StallW = 1'b1;
        drive(1, 1, 2'b10, 3'b000, 5'd3, 32'h5555, 32'h0, 32'h2222);
        for (int i = 0; i < 3; i++) begin
            tick();
            nChecks++; if (ResultW !== 32'hAAAA || RdW !== 5'd9 || RegWriteW !== 1'b1) begin nFail++; $display("FAIL stall_%0d_hold: got res=%h rd=%0d rw=%b want res=0000aaaa rd=9 rw=1", i, ResultW, RdW, RegWriteW); end
            nChecks++; if (InstRetW !== held) begin nFail++; $display("FAIL stall_%0d_instret: got %0d want %0d", i, InstRetW, held); end
        end
        FlushW = 1'b1;
        tick();
        nChecks++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || RdW !== 5'd0) begin nFail++; $display("FAIL stallflush_bubble: got v=%b rw=%b rd=%0d want 0 0 0", ValidW, RegWriteW, RdW); end
        nChecks++; if (InstRetW !== held) begin nFail++; $display("FAIL stallflush_instret: got %0d want %0d", InstRetW, held); end
        StallW = 1'b0; FlushW = 1'b0;
        drive(1, 1, 2'b00, 3'b000, 5'd4, 32'h77, 32'h0, 32'h0);
        tick();
        FlushW = 1'b1;
        tick();
        FlushW = 1'b0;
        nChecks++; if (InstRetW !== held + 64'd1 || ValidW !== 1'b0) begin nFail++; $display("FAIL flush_retires: got cnt=%0d v=%b want cnt=%0d v=0", InstRetW, ValidW, held + 64'd1); end
    endtask

    task automatic test_x0_jal();
        drive(1, 1, 2'b00, 3'b000, 5'd0, 32'h99, 32'h0, 32'h0);
        tick();
        nChecks++; if (RegWriteW !== 1'b0 || ValidW !== 1'b1) begin nFail++; $display("FAIL x0_write: got rw=%b v=%b want rw=0 v=1", RegWriteW, ValidW); end
        drive(1, 1, 2'b10, 3'b000, 5'd1, 32'hDEAD, 32'h0, 32'h104);
        tick();
        nChecks++; if (ResultW !== 32'h104 || RegWriteW !== 1'b1) begin nFail++; $display("FAIL jal_link: got res=%h rw=%b want res=00000104 rw=1", ResultW, RegWriteW); end
        drive(1, 1, 2'b11, 3'b000, 5'd2, 32'hBEEF, 32'h1, 32'h104);
        tick();
        nChecks++; if (ResultW !== 32'hBEEF) begin nFail++; $display("FAIL src11_alu: got %h want 0000beef", ResultW); end
        drive(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        nChecks++; if (InstRetW !== expRet) begin nFail++; $display("FAIL x0_jal_instret: got %0d want %0d", InstRetW, expRet); end
    endtask

    task automatic test_async_reset();
        drive(1, 1, 2'b00, 3'b000, 5'd6, 32'hCAFE, 32'h0, 32'h0);
        tick();
        StallW = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        nChecks++; if ({RegWriteW, RdW, ResultW, ValidW, LoadMisalignW} !== 39'd0) begin nFail++; $display("FAIL async_outputs: got rw=%b rd=%0d res=%h v=%b want all 0", RegWriteW, RdW, ResultW, ValidW); end
        nChecks++; if (InstRetW !== 64'd0) begin nFail++; $display("FAIL async_instret: got %0d want 0", InstRetW); end
        tick();
        StallW = 1'b0; rst_n = 1'b1;
        tick();
        nChecks++; if (ResultW !== 32'hCAFE || InstRetW !== 64'd0) begin nFail++; $display("FAIL post_reset: got res=%h cnt=%0d want 0000cafe 0", ResultW, InstRetW); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_misaligned();
        test_stall_flush();
        test_x0_jal();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
